// File: rtl/fetch_unit.sv
// Instruction fetch stage: walks a PC through mainmem and queues {pc, instruction}
// pairs in a small FIFO for decode, with redirect/flush and misaligned-target halt.
module fetch_unit #(
   parameter logic [31:0] STARTING_ADDR = 32'h0100_0000,
   parameter int unsigned DEPTH         = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_target,
   output logic [31:0] mem_address,
   output logic        mem_read_write,
   input  logic [31:0] mem_data_out,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_data,
   output logic [31:0] inst_pc,
   output logic        misaligned,
   output logic [31:0] fetch_count
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HALT
   } state_t;

   state_t state, state_next;

   logic [31:0]      pc;
   logic [31:0]      fifo_pc   [DEPTH];
   logic [31:0]      fifo_inst [DEPTH];
   logic [PTR_W-1:0] head, tail;
   logic [CNT_W-1:0] count;
   logic [31:0]      hold_pc, hold_inst;
   logic             pop, push, bad_target;

   assign bad_target     = redirect_target[1:0] != 2'b00;
   assign inst_valid     = count != '0;
   assign pop            = inst_valid & inst_ready;
   assign push           = (state == RUN) && ((count < DEPTH_CNT) || pop) && !redirect_valid;
   assign mem_address    = pc;
   assign mem_read_write = 1'b0;

   // When empty the outputs keep showing the last head rather than stale FIFO slots
   assign inst_pc   = inst_valid ? fifo_pc[head]   : hold_pc;
   assign inst_data = inst_valid ? fifo_inst[head] : hold_inst;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (redirect_valid && bad_target) begin
               state_next = HALT;
            end else if (start) begin
               state_next = RUN;
            end
         end
         RUN: begin
            if (redirect_valid && bad_target) begin
               state_next = HALT;
            end
         end
         HALT:    state_next = HALT;
         default: state_next = IDLE;
      endcase
   end

   // A misaligned target leaves the PC where it was so the faulting point stays visible
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         pc          <= STARTING_ADDR;
         misaligned  <= 1'b0;
         fetch_count <= '0;
      end else if (redirect_valid) begin
         if (bad_target) begin
            misaligned <= 1'b1;
         end else if (state != HALT) begin
            pc <= redirect_target;
         end
      end else if (push) begin
         pc          <= pc + 32'd4;
         fetch_count <= fetch_count + 32'd1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head      <= '0;
         tail      <= '0;
         count     <= '0;
         hold_pc   <= '0;
         hold_inst <= '0;
      end else begin
         if (inst_valid) begin
            hold_pc   <= fifo_pc[head];
            hold_inst <= fifo_inst[head];
         end
         if (redirect_valid) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
         end else begin
            if (push) begin
               tail <= tail + 1'b1;
            end
            if (pop) begin
               head <= head + 1'b1;
            end
            case ({push, pop})
               2'b10:   count <= count + 1'b1;
               2'b01:   count <= count - 1'b1;
               default: count <= count;
            endcase
         end
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_pc[tail]   <= pc;
         fifo_inst[tail] <= mem_data_out;
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: behavioural memory, a scoreboard of expected
// {pc, instruction} pairs, a backpressure vector table and hand-written corner sequences.
module tb_fetch_unit;

   logic        clock;
   logic        reset;
   logic        start;
   logic        redirect_valid;
   logic [31:0] redirect_target;
   logic [31:0] mem_address;
   logic        mem_read_write;
   logic [31:0] mem_data_out;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        misaligned;
   logic [31:0] fetch_count;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] data;
   } entry_t;

   typedef struct {
      logic        ready;
      logic        start;
      logic        exp_valid;
      logic [31:0] exp_addr;
      logic [31:0] exp_fc;
   } vec_t;

   entry_t sb_q[$];
   vec_t   vecs[10];

   fetch_unit #(
      .STARTING_ADDR(32'h0100_0000),
      .DEPTH(2)
   ) dut (
      .clock(clock),
      .reset(reset),
      .start(start),
      .redirect_valid(redirect_valid),
      .redirect_target(redirect_target),
      .mem_address(mem_address),
      .mem_read_write(mem_read_write),
      .mem_data_out(mem_data_out),
      .inst_valid(inst_valid),
      .inst_ready(inst_ready),
      .inst_data(inst_data),
      .inst_pc(inst_pc),
      .misaligned(misaligned),
      .fetch_count(fetch_count)
   );

   // Combinational memory: a small program at the base, a distinct pattern everywhere else
   function automatic logic [31:0] memWord(input logic [31:0] addr);
      case (addr)
         32'h0100_0000: memWord = 32'h0000_0513;
         32'h0100_0004: memWord = 32'h0010_0593;
         32'h0100_0008: memWord = 32'h00B5_0533;
         default:       memWord = {addr[15:0], ~addr[15:0]} ^ 32'h1357_9BDF;
      endcase
   endfunction

   assign mem_data_out = memWord(mem_address);

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, required %h", name, act, exp);
      end
   endtask

   task automatic expectEntry(input logic [31:0] addr);
      entry_t e;
      e.pc   = addr;
      e.data = memWord(addr);
      sb_q.push_back(e);
   endtask

   // Scores the head about to be accepted, then advances one clock and settles
   task automatic applyStimulus();
      entry_t e;
      if (inst_valid && inst_ready && !redirect_valid) begin
         if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL sb_extra: got pc=%h data=%h, required no entry", inst_pc, inst_data);
         end else begin
            e = sb_q.pop_front();
            checkOutput("sb_pc", inst_pc, e.pc);
            checkOutput("sb_data", inst_data, e.data);
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic doReset();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      sb_q.delete();
   endtask

   initial begin
      reset           = 1'b1;
      start           = 1'b0;
      redirect_valid  = 1'b0;
      redirect_target = '0;
      inst_ready      = 1'b0;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0100_0000, 32'd0};
      vecs[1] = '{1'b0, 1'b0, 1'b1, 32'h0100_0004, 32'd1};
      vecs[2] = '{1'b0, 1'b0, 1'b1, 32'h0100_0008, 32'd2};
      vecs[3] = '{1'b0, 1'b0, 1'b1, 32'h0100_0008, 32'd2};
      vecs[4] = '{1'b0, 1'b0, 1'b1, 32'h0100_0008, 32'd2};
      vecs[5] = '{1'b0, 1'b0, 1'b1, 32'h0100_0008, 32'd2};
      vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0100_000C, 32'd3};
      vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h0100_0010, 32'd4};
      vecs[8] = '{1'b1, 1'b0, 1'b1, 32'h0100_0014, 32'd5};
      vecs[9] = '{1'b1, 1'b0, 1'b1, 32'h0100_0018, 32'd6};

      #12;
      reset = 1'b0;
      checkOutput("rst_valid", 32'(inst_valid), 32'd0);
      checkOutput("rst_addr", mem_address, 32'h0100_0000);
      checkOutput("rst_rw", 32'(mem_read_write), 32'd0);
      checkOutput("rst_fc", fetch_count, 32'd0);
      checkOutput("rst_misaligned", 32'(misaligned), 32'd0);
      checkOutput("rst_data", inst_data, 32'd0);
      checkOutput("rst_pc", inst_pc, 32'd0);

      // Straight-line fetch with decode always ready
      expectEntry(32'h0100_0000);
      expectEntry(32'h0100_0004);
      expectEntry(32'h0100_0008);
      inst_ready = 1'b1;
      start      = 1'b1;
      applyStimulus();
      start = 1'b0;
      checkOutput("sl_valid_after_start", 32'(inst_valid), 32'd0);
      applyStimulus();
      checkOutput("sl_valid_first_run", 32'(inst_valid), 32'd1);
      checkOutput("sl_fc1", fetch_count, 32'd1);
      applyStimulus();
      applyStimulus();
      checkOutput("sl_fc3", fetch_count, 32'd3);
      applyStimulus();
      inst_ready = 1'b0;
      checkOutput("sl_drained", 32'(sb_q.size()), 32'd0);
      doReset();

      // Backpressure: FIFO fills, PC stalls, then resumes without loss or duplicate
      expectEntry(32'h0100_0000);
      expectEntry(32'h0100_0004);
      expectEntry(32'h0100_0008);
      expectEntry(32'h0100_000C);
      for (int i = 0; i < 10; i++) begin
         inst_ready = vecs[i].ready;
         start      = vecs[i].start;
         applyStimulus();
         checkOutput("bp_valid", 32'(inst_valid), 32'(vecs[i].exp_valid));
         checkOutput("bp_addr", mem_address, vecs[i].exp_addr);
         checkOutput("bp_fc", fetch_count, vecs[i].exp_fc);
      end
      inst_ready = 1'b0;
      start      = 1'b0;
      checkOutput("bp_drained", 32'(sb_q.size()), 32'd0);
      doReset();

      // Redirect while full and decode ready: head is dropped, not consumed
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      applyStimulus();
      applyStimulus();
      inst_ready      = 1'b1;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0100_0040;
      applyStimulus();
      redirect_valid = 1'b0;
      checkOutput("rd_valid", 32'(inst_valid), 32'd0);
      checkOutput("rd_addr", mem_address, 32'h0100_0040);
      checkOutput("rd_fc", fetch_count, 32'd2);
      expectEntry(32'h0100_0040);
      expectEntry(32'h0100_0044);
      applyStimulus();
      applyStimulus();
      applyStimulus();
      inst_ready = 1'b0;
      checkOutput("rd_drained", 32'(sb_q.size()), 32'd0);
      checkOutput("rd_fc5", fetch_count, 32'd5);

      // Misaligned redirect halts with PC frozen; start and aligned redirects are ignored
      redirect_valid  = 1'b1;
      redirect_target = 32'h0100_0042;
      applyStimulus();
      redirect_valid = 1'b0;
      checkOutput("ma_flag", 32'(misaligned), 32'd1);
      checkOutput("ma_addr", mem_address, 32'h0100_004C);
      checkOutput("ma_valid", 32'(inst_valid), 32'd0);
      start      = 1'b1;
      inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         applyStimulus();
         checkOutput("halt_valid", 32'(inst_valid), 32'd0);
         checkOutput("halt_addr", mem_address, 32'h0100_004C);
         checkOutput("halt_fc", fetch_count, 32'd5);
      end
      start           = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'h0100_0080;
      applyStimulus();
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      checkOutput("halt_redirect_addr", mem_address, 32'h0100_004C);
      checkOutput("halt_sticky", 32'(misaligned), 32'd1);

      // Asynchronous reset between edges clears the halt immediately
      reset = 1'b1;
      #1;
      checkOutput("arst_halt_misaligned", 32'(misaligned), 32'd0);
      checkOutput("arst_halt_addr", mem_address, 32'h0100_0000);
      #1;
      reset = 1'b0;
      sb_q.delete();

      // Asynchronous reset with two entries buffered
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      applyStimulus();
      applyStimulus();
      checkOutput("arst_pre_valid", 32'(inst_valid), 32'd1);
      #2;
      reset = 1'b1;
      #1;
      checkOutput("arst_valid", 32'(inst_valid), 32'd0);
      checkOutput("arst_fc", fetch_count, 32'd0);
      checkOutput("arst_addr", mem_address, 32'h0100_0000);
      checkOutput("arst_misaligned", 32'(misaligned), 32'd0);
      reset = 1'b0;
      sb_q.delete();

      // Redirect in IDLE loads PC without starting
      applyStimulus();
      redirect_valid  = 1'b1;
      redirect_target = 32'h0100_0100;
      applyStimulus();
      redirect_valid = 1'b0;
      checkOutput("idle_rd_addr", mem_address, 32'h0100_0100);
      applyStimulus();
      checkOutput("idle_rd_valid", 32'(inst_valid), 32'd0);
      checkOutput("idle_rd_fc", fetch_count, 32'd0);
      start = 1'b1;
      applyStimulus();
      start = 1'b0;
      applyStimulus();
      checkOutput("idle_rd_head_pc", inst_pc, 32'h0100_0100);
      checkOutput("idle_rd_head_data", inst_data, memWord(32'h0100_0100));
      doReset();

      // PC wrap-around from the top of the address space
      start = 1'b1;
      applyStimulus();
      start           = 1'b0;
      redirect_valid  = 1'b1;
      redirect_target = 32'hFFFF_FFFC;
      applyStimulus();
      redirect_valid = 1'b0;
      checkOutput("wrap_addr", mem_address, 32'hFFFF_FFFC);
      expectEntry(32'hFFFF_FFFC);
      expectEntry(32'h0000_0000);
      expectEntry(32'h0000_0004);
      inst_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         applyStimulus();
      end
      inst_ready = 1'b0;
      checkOutput("wrap_drained", 32'(sb_q.size()), 32'd0);
      checkOutput("wrap_rw", 32'(mem_read_write), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
